seg7_capture: RTL and testbench
===============================

# seg7_capture

Recovers hex digit values from a multiplexed, active-low 7-segment display bus: the same segment/anode signals our display drivers put on the board pins. It debounces each (anode, segment) pair over a stability window, decodes the segment pattern back to a 4-bit value, and keeps one register per digit position. It sits on the bench/loopback side of the display path, giving self-checking display tests and capture of an external display's contents.

## Interface

Parameters:

- `NDIG`, default 8: number of multiplexed digit positions (anodes).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before capture. Legal values are 1..255.

Ports:

- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `seg_n`  in  7: segment lines, active-low, bit0=a … bit6=g.
- `an_n`  in  NDIG: digit select, active-low; exactly one low bit selects a digit.
- `digits`  out  4*NDIG: captured values; digit i occupies `[4i+3:4i]`.
- `dig_valid`  out  NDIG: digit i currently holds a decoded hex value.
- `dig_err`  out  NDIG: last capture for digit i was an unrecognised pattern.
- `upd_valid`  out  1: one-cycle pulse per capture event.
- `upd_idx`  out  $clog2(NDIG): digit index of the capture; valid with `upd_valid`.
- `upd_value`  out  4: decoded value; 0 on blank or error.
- `upd_err`  out  1: capture pattern was unrecognised.

## Operation

- **Decode table** (seg_n, hex of 7 bits):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - 7F is blank. Every other pattern is an error.
- **Input stage:** `seg_n` and `an_n` are registered every cycle into `in_q`. The reset value of `in_q` is all-ones.
- **Stability counter `cnt`:**
  - Width is $clog2(STABLE_CYCLES+1).
  - If `in_q` differs from its previous value, `cnt` becomes 1. Otherwise `cnt` increments, saturating at STABLE_CYCLES.
- **Capture:** occurs on the cycle `cnt` first reaches STABLE_CYCLES, only if `in_q.an_n` has exactly one zero bit.
  - Captures occur at most once per held pair. A new capture requires a change followed by a fresh full window.
- **`an_n` all-ones** (inter-digit blanking): `cnt` tracks normally, but no capture occurs.
- **`an_n` with two or more low bits:** treated as a conflict. No capture occurs.
- **Capture effects for digit i:**
  - Hex hit: `digits[i]`=value, `dig_valid[i]`=1, `dig_err[i]`=0.
  - Blank: `digits[i]`=0, `dig_valid[i]`=0, `dig_err[i]`=0.
  - Error: `digits[i]` is unchanged, `dig_valid[i]`=0, `dig_err[i]`=1.
  - In all three cases `upd_valid` pulses with `upd_idx`=i, and `upd_err` is set for the error case only.
- **Reset values:** all outputs are 0, `cnt`=0, and `in_q` is all-ones. Reset asserted mid-window discards the window. After reset, any pair needs a complete stable window before it is captured.

## Timing

- The pair must be present on the pins before rising edge E1 and held.
- With the pair held through E(STABLE_CYCLES), the registered outputs (`digits`, `dig_valid`, `dig_err`, `upd_*`) change after edge E(STABLE_CYCLES+1).
  - For STABLE_CYCLES=4 the update is visible after E5.
- `upd_valid` is high for exactly one cycle. All capture outputs update on the same edge.
- A change seen by the input stage at or before the completing sample restarts the window, so nothing is captured from that pair.
- A new pair becomes eligible for capture STABLE_CYCLES+1 cycles after it appears.
- There are no combinational paths from input to output.

## Structure

- **Package `seg7_pkg`:**
  - Constants `SEG7_0` … `SEG7_F` and `SEG7_BLANK` (7'h7F).
  - `SEG7_W`=7.
  - The display encoder and this block must share these constants.
- **Sub-module `seg7_decode`:** purely combinational; maps `seg_n[6:0]` to `{hit, blank, value[3:0]}`.
- **Top-level module:** contains the input register, the stability counter, the one-hot check, and the per-digit register file.

## Test plan

- **Reset:** assert `rst` 3 cycles with random inputs. All outputs must be 0 throughout and the cycle after release.
- **Single capture:** `an_n`=8'b1111_1011, `seg_n`=7'h30, held 8 cycles.
  - Exactly one `upd_valid` pulse after E5, with `upd_idx`=2, `upd_value`=3.
  - `digits[11:8]`=3 and `dig_valid`=8'h04.
- **Glitch rejection:** the same pair held 3 cycles, then changed. No `upd_valid` pulse and no change to `digits`.
- **Error pattern:** `an_n`=8'hFE, `seg_n`=7'h7E, held 6 cycles.
  - `upd_err`=1 and `dig_err[0]`=1.
  - `dig_valid[0]`=0 and `digits[3:0]` retains its prior value.
- **Anode conflict/blanking:** `an_n`=8'hFC held 10 cycles, then `an_n`=8'hFF held 10 cycles. Zero capture events.
- **Full scan and reset:**
  - Scan digits i=0..7 showing value i, holding each 5 cycles, separated by 1 cycle of `an_n`=8'hFF. Expect 8 pulses in order, `digits`=32'h76543210, `dig_valid`=8'hFF.
  - Then assert `rst` on cycle 3 of a hold. No pulse, and all outputs are cleared.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared active-low 7-segment encodings and decode result type.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int SEG7_W = 7;

    // Active-low patterns, bit0 = a ... bit6 = g
    localparam logic [SEG7_W-1:0] SEG7_0     = 7'h40;
    localparam logic [SEG7_W-1:0] SEG7_1     = 7'h79;
    localparam logic [SEG7_W-1:0] SEG7_2     = 7'h24;
    localparam logic [SEG7_W-1:0] SEG7_3     = 7'h30;
    localparam logic [SEG7_W-1:0] SEG7_4     = 7'h19;
    localparam logic [SEG7_W-1:0] SEG7_5     = 7'h12;
    localparam logic [SEG7_W-1:0] SEG7_6     = 7'h02;
    localparam logic [SEG7_W-1:0] SEG7_7     = 7'h78;
    localparam logic [SEG7_W-1:0] SEG7_8     = 7'h00;
    localparam logic [SEG7_W-1:0] SEG7_9     = 7'h10;
    localparam logic [SEG7_W-1:0] SEG7_A     = 7'h08;
    localparam logic [SEG7_W-1:0] SEG7_B     = 7'h03;
    localparam logic [SEG7_W-1:0] SEG7_C     = 7'h46;
    localparam logic [SEG7_W-1:0] SEG7_D     = 7'h21;
    localparam logic [SEG7_W-1:0] SEG7_E     = 7'h06;
    localparam logic [SEG7_W-1:0] SEG7_F     = 7'h0E;
    localparam logic [SEG7_W-1:0] SEG7_BLANK = 7'h7F;

    typedef struct packed {
        logic       hit;
        logic       blank;
        logic [3:0] value;
    } seg7_dec_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational map from active-low segment pattern to hex value.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG7_W-1:0] seg_n,
    output seg7_dec_t         dec
);

    logic [3:0] w_value;
    logic       w_hit;

    always_comb begin
        w_value = 4'h0;
        w_hit   = 1'b1;
        case (seg_n)
            SEG7_0:  w_value = 4'h0;
            SEG7_1:  w_value = 4'h1;
            SEG7_2:  w_value = 4'h2;
            SEG7_3:  w_value = 4'h3;
            SEG7_4:  w_value = 4'h4;
            SEG7_5:  w_value = 4'h5;
            SEG7_6:  w_value = 4'h6;
            SEG7_7:  w_value = 4'h7;
            SEG7_8:  w_value = 4'h8;
            SEG7_9:  w_value = 4'h9;
            SEG7_A:  w_value = 4'hA;
            SEG7_B:  w_value = 4'hB;
            SEG7_C:  w_value = 4'hC;
            SEG7_D:  w_value = 4'hD;
            SEG7_E:  w_value = 4'hE;
            SEG7_F:  w_value = 4'hF;
            default: w_hit   = 1'b0;
        endcase
        dec.hit   = w_hit;
        dec.blank = (seg_n == SEG7_BLANK);
        dec.value = w_hit ? w_value : 4'h0;
    end

endmodule
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_capture
//  Description : Debounces a multiplexed active-low 7-seg bus and keeps one
//                decoded hex value per digit position.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NDIG          = 8,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEG7_W-1:0]   seg_n,
    input  logic [NDIG-1:0]     an_n,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dig_valid,
    output logic [NDIG-1:0]     dig_err,
    output logic                upd_valid,
    output logic [IDX_W-1:0]    upd_idx,
    output logic [3:0]          upd_value,
    output logic                upd_err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef struct packed {
        logic [NDIG-1:0]   an_n;
        logic [SEG7_W-1:0] seg_n;
    } pins_t;

    pins_t               in_q, in_d, prev_q, prev_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*NDIG-1:0]   digits_q, digits_d;
    logic [NDIG-1:0]     dig_valid_q, dig_valid_d;
    logic [NDIG-1:0]     dig_err_q, dig_err_d;
    logic                upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0]    upd_idx_q, upd_idx_d;
    logic [3:0]          upd_value_q, upd_value_d;
    logic                upd_err_q, upd_err_d;

    seg7_dec_t           w_dec;
    logic [NDIG-1:0]     w_an;
    logic                w_onehot;
    logic [IDX_W-1:0]    w_idx;
    logic                w_changed;
    logic                w_reach;
    logic                w_capture;

    seg7_decode u_decode (
        .seg_n (in_q.seg_n),
        .dec   (w_dec)
    );

    always_comb begin
        w_an     = ~in_q.an_n;
        w_onehot = (w_an != '0) && ((w_an & (w_an - NDIG'(1))) == '0);
        w_idx    = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_an[i]) w_idx = IDX_W'(i);
        end
    end

    // prev_q holds the previous in_q, so the window starts one edge after the
    // pins are sampled and completes on the edge that also loads the outputs.
    always_comb begin
        in_d      = pins_t'({an_n, seg_n});
        prev_d    = in_q;
        w_changed = (in_q != prev_q);
        w_reach   = w_changed ? (c_cnt_max == c_cnt_one)
                              : (cnt_q == c_cnt_max - c_cnt_one);
        w_capture = w_reach && w_onehot;
        if (w_changed)              cnt_d = c_cnt_one;
        else if (cnt_q == c_cnt_max) cnt_d = cnt_q;
        else                        cnt_d = cnt_q + c_cnt_one;
    end

    always_comb begin
        digits_d    = digits_q;
        dig_valid_d = dig_valid_q;
        dig_err_d   = dig_err_q;
        upd_valid_d = 1'b0;
        upd_idx_d   = '0;
        upd_value_d = 4'h0;
        upd_err_d   = 1'b0;
        if (w_capture) begin
            upd_valid_d = 1'b1;
            upd_idx_d   = w_idx;
            if (w_dec.hit) begin
                digits_d[4*int'(w_idx) +: 4] = w_dec.value;
                dig_valid_d[w_idx]           = 1'b1;
                dig_err_d[w_idx]             = 1'b0;
                upd_value_d                  = w_dec.value;
            end else if (w_dec.blank) begin
                digits_d[4*int'(w_idx) +: 4] = 4'h0;
                dig_valid_d[w_idx]           = 1'b0;
                dig_err_d[w_idx]             = 1'b0;
            end else begin
                dig_valid_d[w_idx] = 1'b0;
                dig_err_d[w_idx]   = 1'b1;
                upd_err_d          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q        <= '1;
            prev_q      <= '1;
            cnt_q       <= '0;
            digits_q    <= '0;
            dig_valid_q <= '0;
            dig_err_q   <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_value_q <= 4'h0;
            upd_err_q   <= 1'b0;
        end else begin
            in_q        <= in_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            dig_valid_q <= dig_valid_d;
            dig_err_q   <= dig_err_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_value_q <= upd_value_d;
            upd_err_q   <= upd_err_d;
        end
    end

    assign digits    = digits_q;
    assign dig_valid = dig_valid_q;
    assign dig_err   = dig_err_q;
    assign upd_valid = upd_valid_q;
    assign upd_idx   = upd_idx_q;
    assign upd_value = upd_value_q;
    assign upd_err   = upd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_capture
//  Description : Scoreboard bench for seg7_capture (NDIG=8, STABLE_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_capture;

    localparam int NDIG   = 8;
    localparam int STABLE = 4;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic [31:0] digits;
    logic [7:0]  dig_valid;
    logic [7:0]  dig_err;
    logic        upd_valid;
    logic [2:0]  upd_idx;
    logic [3:0]  upd_value;
    logic        upd_err;

    seg7_capture #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .digits    (digits),
        .dig_valid (dig_valid),
        .dig_err   (dig_err),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_value (upd_value),
        .upd_err   (upd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [3:0] val;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_digits;
    logic [7:0]  m_valid;
    logic [7:0]  m_err;
    int          checks   = 0;
    int          failures = 0;

    logic [6:0] ref_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // {hit, blank, value}
    function automatic logic [5:0] ref_dec(input logic [6:0] s);
        logic [5:0] r;
        r = (s == 7'h7F) ? 6'b01_0000 : 6'b00_0000;
        for (int v = 0; v < 16; v++) begin
            if (s == ref_seg[v]) r = {2'b10, 4'(v)};
        end
        return r;
    endfunction

    task automatic drive_pair(input logic [7:0] an, input logic [6:0] seg, input int n);
        logic [5:0] d;
        exp_t       e;
        an_n  = an;
        seg_n = seg;
        if (n >= STABLE && $countones(~an) == 1) begin
            e.idx = 0;
            for (int k = 0; k < NDIG; k++) if (!an[k]) e.idx = k;
            d     = ref_dec(seg);
            e.cyc = cyc + STABLE + 1;
            e.err = !d[5] && !d[4];
            e.val = d[5] ? d[3:0] : 4'h0;
            if (d[5]) begin
                m_digits[4*e.idx +: 4] = d[3:0];
                m_valid[e.idx] = 1'b1;
                m_err[e.idx]   = 1'b0;
            end else if (d[4]) begin
                m_digits[4*e.idx +: 4] = 4'h0;
                m_valid[e.idx] = 1'b0;
                m_err[e.idx]   = 1'b0;
            end else begin
                m_valid[e.idx] = 1'b0;
                m_err[e.idx]   = 1'b1;
            end
            exp_q.push_back(e);
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive_pair(8'hFF, 7'h7F, n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digits"}, digits, 32'h0);
        check({tag, "_valid"}, {24'h0, dig_valid}, 32'h0);
        check({tag, "_err"}, {24'h0, dig_err}, 32'h0);
        check({tag, "_upd"}, {22'h0, upd_valid, upd_idx, upd_value, upd_err}, 32'h0);
    endtask

    task automatic end_phase(input string tag);
        check({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, "_digits"}, digits, m_digits);
        check({tag, "_valid"}, {24'h0, dig_valid}, {24'h0, m_valid});
        check({tag, "_err"}, {24'h0, dig_err}, {24'h0, m_err});
    endtask

    always @(negedge clk) begin
        if (upd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_upd", {29'h0, upd_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("upd_cycle", cyc, e.cyc);
                check("upd_idx", {29'h0, upd_idx}, e.idx);
                check("upd_value", {28'h0, upd_value}, {28'h0, e.val});
                check("upd_err", {31'h0, upd_err}, {31'h0, e.err});
            end
        end
    end

    initial begin
        m_digits = '0;
        m_valid  = '0;
        m_err    = '0;
        rst      = 1'b1;
        an_n     = 8'($urandom);
        seg_n    = 7'($urandom);

        // reset with random pins
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_zero("reset");
            an_n  = 8'($urandom);
            seg_n = 7'($urandom);
        end
        rst   = 1'b0;
        an_n  = 8'hFF;
        seg_n = 7'h7F;
        @(negedge clk);
        check_zero("post_reset");

        // single capture: digit 2 shows 3
        drive_pair(8'hFB, 7'h30, 8);
        idle(3);
        end_phase("single");
        check("single_nibble", {28'h0, digits[11:8]}, 32'h3);
        check("single_valid", {24'h0, dig_valid}, 32'h04);

        // glitch: same pair only 3 cycles
        drive_pair(8'hFB, 7'h30, 3);
        idle(6);
        end_phase("glitch");

        // error keeps prior nibble, blank clears
        drive_pair(8'hFE, 7'h12, 6);
        idle(2);
        drive_pair(8'hFE, 7'h7E, 6);
        idle(2);
        check("error_nibble", {28'h0, digits[3:0]}, 32'h5);
        check("error_flag", {31'h0, dig_err[0]}, 32'h1);
        drive_pair(8'hFD, 7'h7F, 5);
        idle(3);
        end_phase("error_blank");

        // anode conflict then blanking
        drive_pair(8'hFC, 7'h30, 10);
        drive_pair(8'hFF, 7'h30, 10);
        idle(2);
        end_phase("conflict");

        // full scan
        for (int i = 0; i < NDIG; i++) begin
            drive_pair(~(8'h01 << i), ref_seg[i], 5);
            idle(1);
        end
        idle(4);
        end_phase("scan");
        check("scan_literal", digits, 32'h7654_3210);
        check("scan_valid_literal", {24'h0, dig_valid}, 32'hFF);

        // reset on cycle 3 of a hold, then a fresh window after release
        an_n  = 8'hF7;
        seg_n = 7'h10;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("mid_reset");
        rst      = 1'b0;
        m_digits = '0;
        m_valid  = '0;
        m_err    = '0;
        drive_pair(8'hF7, 7'h10, 6);
        idle(3);
        end_phase("after_reset");
        check("after_reset_literal", digits, 32'h0000_9000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
